sr_decode_stage: RTL and testbench
==================================

# sr_decode_stage

Registered RV32I instruction decode stage with valid/ready handshakes on both sides. It sits between fetch and execute in the pipelined schoolRISCV core. It extends plain field extraction with five things: format classification, a single format-selected immediate sign-extended to XLEN, illegal-opcode detection, optional NOP dropping, and a flush. Output is buffered by either a 2-entry skid buffer or a single pipeline register.

## Interface
- XLEN, 32: datapath width; 32 or 64. Immediates and PC are sign-extended or carried at this width.
- DROP_NOOP, 0: when 1, accepted canonical NOPs are consumed and never presented at the output.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  instruction address; passed through unchanged.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  downstream accepts this cycle.
- out_pc  out  XLEN  PC of the presented entry.
- out_op  out  7  opcode, instr[6:0].
- out_rd, out_rs1, out_rs2  out  5 each  instr[11:7], instr[19:15], instr[24:20].
- out_f3  out  3  instr[14:12].
- out_f7  out  7  instr[31:25].
- out_fmt  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, X=7 (illegal).
- out_imm  out  XLEN  format-selected immediate, sign-extended.
- out_illegal  out  1  unrecognised encoding.
- out_noop  out  1  instr == 32'h0000_0013.

## Operation
- Format by opcode:
  - U: 0110111, 0010111.
  - J: 1101111.
  - I: 1100111, 0000011, 0010011, 0001111, 1110011.
  - B: 1100011.
  - S: 0100011.
  - R: 0110011.
  - Anything else, or instr[1:0] != 2'b11: format X with out_illegal = 1.
- Immediates, sign bit always instr[31], extended to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - R and X: imm = 0.
- Register fields are always passed through raw, whatever the format.
- out_noop is set only on an exact match of 32'h0000_0013.
- Handshake:
  - Transfer in: in_valid && in_ready.
  - Transfer out: out_valid && out_ready.
  - While out_valid && !out_ready, every out_* signal holds stable.
  - Entries leave in acceptance order, with no loss and no duplication.
- DROP_NOOP = 1: an accepted NOP is discarded (out_noop is then never 1). in_ready behaves as for any other accept.
- Flush:
  - All buffered entries are invalidated at the edge.
  - in_ready = 0 while flush = 1, so nothing is accepted in a flush cycle.
  - Flush overrides out_ready; an entry presented during flush may be taken downstream, but it is removed regardless.
- Reset values: out_valid = 0, all payload outputs 0, out_fmt = 0, in_ready = 1. Reset mid-stream discards every held entry.

## Timing
- Latency: an instruction accepted at edge N is presented with out_valid = 1 after edge N, so it is visible in cycle N+1.
- Sustained throughput is 1 per cycle while out_ready = 1.
- in_ready depends combinationally only on flush plus internal state; there is no in_valid→in_ready or out_ready→in_ready path (skid build).
- Simultaneous transfer in and out in one cycle with one entry held: occupancy stays 1 and the new entry is presented next cycle.

## Configuration
- SR_DECODE_SKID_EN defined:
  - 2-entry skid buffer.
  - in_ready = (occupancy < 2) && !flush, taken from a register.
  - With out_ready low, two further accepts succeed before in_ready drops.
- SR_DECODE_SKID_EN undefined:
  - Single output register.
  - in_ready = (!out_valid || out_ready) && !flush, a combinational path from out_ready.
  - Only one accept succeeds while stalled.
- All other behaviour is identical in both builds.

## Structure
- Package sr_decode_pkg holds:
  - the fmt_t enum (3 bits);
  - the RVOP opcode localparams;
  - the NOP constant 32'h0000_0013;
  - a decoded-entry packed struct parametrised by XLEN, or a width-generic layout.
- Sub-module sr_decode_fields: purely combinational instr → {fields, fmt, imm, illegal, noop}. It is instantiated once, ahead of the storage.
- Storage and handshake control live in sr_decode_stage.

## Test plan
- 0xFFF10093 (addi x1,x2,-1), out_ready = 1 → next cycle out_valid = 1, fmt I, imm 0xFFFFFFFF, rd 1, rs1 2.
- 0x00512423 (sw x5,8(x2)) → fmt S, imm 8, rs2 5; then 0xFE000EE3 (beq x0,x0,-4) → fmt B, imm 0xFFFFFFFC.
- XLEN = 64, 0x800000B7 (lui x1,0x80000) → fmt U, imm 0xFFFFFFFF80000000; 0x00000000 → out_illegal = 1, fmt X, imm 0.
- Stream 5 instructions with out_ready low for 3 cycles → in_ready falls after 2 accepts (skid) or 1 accept (no skid); output order and count exactly match input.
- 0x00000013: DROP_NOOP = 0 → out_noop = 1; DROP_NOOP = 1 → no out_valid, and the next instruction appears 1 cycle after its own accept.
- Two entries held plus in_valid = 1, then pulse flush → out_valid = 0 next cycle, no input accepted in the flush cycle; assert rst mid-stream → out_valid = 0 immediately, in_ready = 1 after release.

Source files
------------

// File: rtl/sr_decode_pkg.sv
// sr_decode_pkg
// Shared definitions for the RV32I decode stage:
//   - fmt_t       : 3-bit instruction format code (R/I/S/B/U/J, X = illegal)
//   - RVOP_*      : base opcode values recognised by the decoder
//   - NOP_INSTR   : canonical NOP encoding (addi x0,x0,0)
//   - dec_fields_t: width-generic part of a decoded entry. The XLEN-wide
//                   pc and immediate are carried next to it by the users.
//   - fmt_of      : opcode -> format classification
package sr_decode_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_X = 3'd7
  } fmt_t;

  localparam logic [6:0] RVOP_LUI     = 7'b0110111;
  localparam logic [6:0] RVOP_AUIPC   = 7'b0010111;
  localparam logic [6:0] RVOP_JAL     = 7'b1101111;
  localparam logic [6:0] RVOP_JALR    = 7'b1100111;
  localparam logic [6:0] RVOP_LOAD    = 7'b0000011;
  localparam logic [6:0] RVOP_OPIMM   = 7'b0010011;
  localparam logic [6:0] RVOP_MISCMEM = 7'b0001111;
  localparam logic [6:0] RVOP_SYSTEM  = 7'b1110011;
  localparam logic [6:0] RVOP_BRANCH  = 7'b1100011;
  localparam logic [6:0] RVOP_STORE   = 7'b0100011;
  localparam logic [6:0] RVOP_OP      = 7'b0110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [6:0] op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    fmt_t       fmt;
    logic       illegal;
    logic       noop;
  } dec_fields_t;

  // Every legal opcode ends in 2'b11, so the explicit compare list already
  // rejects compressed/reserved quadrants; the low-bit test is kept for
  // clarity of intent.
  function automatic fmt_t fmt_of(input logic [6:0] op);
    fmt_t f;
    f = FMT_X;
    if (op[1:0] == 2'b11) begin
      case (op)
        RVOP_LUI, RVOP_AUIPC:                       f = FMT_U;
        RVOP_JAL:                                   f = FMT_J;
        RVOP_JALR, RVOP_LOAD, RVOP_OPIMM,
        RVOP_MISCMEM, RVOP_SYSTEM:                  f = FMT_I;
        RVOP_BRANCH:                                f = FMT_B;
        RVOP_STORE:                                 f = FMT_S;
        RVOP_OP:                                    f = FMT_R;
        default:                                    f = FMT_X;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/sr_decode_fields.sv
// sr_decode_fields
// Purely combinational RV32I field extraction and classification.
// Ports:
//   instr  in  32    raw instruction word
//   fields out       op/rd/rs1/rs2/f3/f7 (raw), fmt, illegal, noop
//   imm    out XLEN  format-selected immediate, sign-extended from instr[31]
module sr_decode_fields
  import sr_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output dec_fields_t     fields,
  output logic [XLEN-1:0] imm
);

  fmt_t              fmt;
  logic signed [31:0] imm32;

  assign fmt = fmt_of(instr[6:0]);

  always_comb begin
    fields         = '0;
    fields.op      = instr[6:0];
    fields.rd      = instr[11:7];
    fields.rs1     = instr[19:15];
    fields.rs2     = instr[24:20];
    fields.f3      = instr[14:12];
    fields.f7      = instr[31:25];
    fields.fmt     = fmt;
    fields.illegal = (fmt == FMT_X);
    fields.noop    = (instr == NOP_INSTR);
  end

  // All immediates fit in 32 bits; build them there, then widen.
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // imm32 is signed, so the size cast sign-extends when XLEN = 64.
  assign imm = XLEN'(imm32);

endmodule

// File: rtl/sr_decode_stage.sv
// sr_decode_stage
// Registered RV32I decode stage with valid/ready handshakes on both sides.
// The instruction is decoded combinationally on the way in and the decoded
// entry is stored, so outputs come straight from registers.
//
// Build option (macro SR_DECODE_SKID_EN):
//   defined   : 2-entry skid buffer; in_ready comes from a register and only
//               depends on occupancy and flush.
//   undefined : single output register; in_ready = (!out_valid || out_ready)
//               && !flush.
//
// Parameters:
//   XLEN      : 32 or 64, width of pc and immediate.
//   DROP_NOOP : 1 -> accepted canonical NOPs are consumed, never presented.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous kill of every buffered entry
//   in_valid/in_ready   upstream handshake; in_instr, in_pc payload
//   out_valid/out_ready downstream handshake
//   out_pc, out_op, out_rd, out_rs1, out_rs2, out_f3, out_f7,
//   out_fmt, out_imm, out_illegal, out_noop  decoded entry
module sr_decode_stage
  import sr_decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DROP_NOOP = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_op,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_f3,
  output logic [6:0]      out_f7,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal,
  output logic            out_noop
);

`ifdef SR_DECODE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  // Decode ahead of storage.
  dec_fields_t     dec_fields;
  logic [XLEN-1:0] dec_imm;

  sr_decode_fields #(
    .XLEN(XLEN)
  ) u_fields (
    .instr (in_instr),
    .fields(dec_fields),
    .imm   (dec_imm)
  );

  // Entry 0 is always the presented (oldest) entry.
  logic [DEPTH-1:0] valid_reg;
  dec_fields_t      fld_reg [DEPTH];
  logic [XLEN-1:0]  pc_reg  [DEPTH];
  logic [XLEN-1:0]  imm_reg [DEPTH];

  logic accept;
  logic store;
  logic pop;

  assign accept = in_valid && in_ready;
  // A dropped NOP is still a normal accept upstream; it just never lands.
  assign store  = accept && !((DROP_NOOP != 0) && dec_fields.noop);
  assign pop    = valid_reg[0] && out_ready;

`ifdef SR_DECODE_SKID_EN

  // valid_reg[1] is the "full" flag, so in_ready is a register gated by flush.
  assign in_ready = !valid_reg[1] && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fld_reg[i] <= '0;
        pc_reg[i]  <= '0;
        imm_reg[i] <= '0;
      end
    end else if (flush) begin
      // in_ready is low here, so nothing new can be lost.
      valid_reg <= '0;
    end else if (pop) begin
      if (valid_reg[1]) begin
        // Skid entry moves to the head; the incoming one takes its slot.
        fld_reg[0]   <= fld_reg[1];
        pc_reg[0]    <= pc_reg[1];
        imm_reg[0]   <= imm_reg[1];
        fld_reg[1]   <= dec_fields;
        pc_reg[1]    <= in_pc;
        imm_reg[1]   <= dec_imm;
        valid_reg[1] <= store;
      end else begin
        if (store) begin
          fld_reg[0] <= dec_fields;
          pc_reg[0]  <= in_pc;
          imm_reg[0] <= dec_imm;
        end
        valid_reg[0] <= store;
      end
    end else if (store) begin
      if (!valid_reg[0]) begin
        fld_reg[0]   <= dec_fields;
        pc_reg[0]    <= in_pc;
        imm_reg[0]   <= dec_imm;
        valid_reg[0] <= 1'b1;
      end else begin
        fld_reg[1]   <= dec_fields;
        pc_reg[1]    <= in_pc;
        imm_reg[1]   <= dec_imm;
        valid_reg[1] <= 1'b1;
      end
    end
  end

`else

  // The slot frees up in the same cycle it is consumed downstream.
  assign in_ready = (!valid_reg[0] || out_ready) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg  <= '0;
      fld_reg[0] <= '0;
      pc_reg[0]  <= '0;
      imm_reg[0] <= '0;
    end else if (flush) begin
      valid_reg <= '0;
    end else if (!valid_reg[0] || out_ready) begin
      // Payload is only overwritten by a stored entry, so a popped slot
      // with nothing behind it simply goes invalid.
      if (store) begin
        fld_reg[0] <= dec_fields;
        pc_reg[0]  <= in_pc;
        imm_reg[0] <= dec_imm;
      end
      valid_reg[0] <= store;
    end
  end

`endif

  assign out_valid   = valid_reg[0];
  assign out_pc      = pc_reg[0];
  assign out_imm     = imm_reg[0];
  assign out_op      = fld_reg[0].op;
  assign out_rd      = fld_reg[0].rd;
  assign out_rs1     = fld_reg[0].rs1;
  assign out_rs2     = fld_reg[0].rs2;
  assign out_f3      = fld_reg[0].f3;
  assign out_f7      = fld_reg[0].f7;
  assign out_fmt     = fld_reg[0].fmt;
  assign out_illegal = fld_reg[0].illegal;
  assign out_noop    = fld_reg[0].noop;

endmodule

// File: tb/tb_sr_decode_stage.sv
// Scoreboard bench for sr_decode_stage. Two instances share the clock and
// reset: "a" (XLEN=32, DROP_NOOP=0) and "b" (XLEN=64, DROP_NOOP=1).
module tb_sr_decode_stage;

`ifdef SR_DECODE_SKID_EN
  localparam int STALL_ACC = 2;
`else
  localparam int STALL_ACC = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic a_flush, b_flush;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_instr, a_in_pc, a_out_pc, a_out_imm;
  logic [6:0]  a_out_op, a_out_f7;
  logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2;
  logic [2:0]  a_out_f3, a_out_fmt;
  logic        a_out_illegal, a_out_noop;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_instr;
  logic [63:0] b_in_pc, b_out_pc, b_out_imm;
  logic [6:0]  b_out_op, b_out_f7;
  logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
  logic [2:0]  b_out_f3, b_out_fmt;
  logic        b_out_illegal, b_out_noop;

  always #5 clk = ~clk;

  sr_decode_stage #(.XLEN(32), .DROP_NOOP(0)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_instr(a_in_instr), .in_pc(a_in_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_pc(a_out_pc), .out_op(a_out_op), .out_rd(a_out_rd),
    .out_rs1(a_out_rs1), .out_rs2(a_out_rs2), .out_f3(a_out_f3),
    .out_f7(a_out_f7), .out_fmt(a_out_fmt), .out_imm(a_out_imm),
    .out_illegal(a_out_illegal), .out_noop(a_out_noop)
  );

  sr_decode_stage #(.XLEN(64), .DROP_NOOP(1)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_in_instr), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pc(b_out_pc), .out_op(b_out_op), .out_rd(b_out_rd),
    .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_f3(b_out_f3),
    .out_f7(b_out_f7), .out_fmt(b_out_fmt), .out_imm(b_out_imm),
    .out_illegal(b_out_illegal), .out_noop(b_out_noop)
  );

  // Hand-decoded vectors; imm is the 64-bit sign-extended value.
  typedef struct {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        illegal, noop;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [36:0] f;
  } exp_t;

  vec_t tbl [11];
  exp_t qa [$];
  exp_t qb [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic exp_t mk_exp(input int v, input logic [63:0] pc, input bit wide);
    exp_t e;
    e.pc  = wide ? pc : {32'b0, pc[31:0]};
    e.imm = wide ? tbl[v].imm : {32'b0, tbl[v].imm[31:0]};
    e.f   = {tbl[v].op, tbl[v].rd, tbl[v].rs1, tbl[v].rs2, tbl[v].f3,
             tbl[v].f7, tbl[v].fmt, tbl[v].illegal, tbl[v].noop};
    return e;
  endfunction

  // Monitors: compare on every downstream transfer.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      chk("a_sb_nonempty", 64'(qa.size() != 0), 64'd1);
      if (qa.size() != 0) begin
        exp_t e;
        e = qa.pop_front();
        chk("a_pc", {32'b0, a_out_pc}, e.pc);
        chk("a_imm", {32'b0, a_out_imm}, e.imm);
        chk("a_fields", 64'({a_out_op, a_out_rd, a_out_rs1, a_out_rs2, a_out_f3,
                             a_out_f7, a_out_fmt, a_out_illegal, a_out_noop}), 64'(e.f));
        $display("a out: pc=%h op=%h fmt=%0d imm=%h illegal=%0b noop=%0b",
                 a_out_pc, a_out_op, a_out_fmt, a_out_imm, a_out_illegal, a_out_noop);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      chk("b_sb_nonempty", 64'(qb.size() != 0), 64'd1);
      if (qb.size() != 0) begin
        exp_t e;
        e = qb.pop_front();
        chk("b_pc", b_out_pc, e.pc);
        chk("b_imm", b_out_imm, e.imm);
        chk("b_fields", 64'({b_out_op, b_out_rd, b_out_rs1, b_out_rs2, b_out_f3,
                             b_out_f7, b_out_fmt, b_out_illegal, b_out_noop}), 64'(e.f));
        $display("b out: pc=%h op=%h fmt=%0d imm=%h illegal=%0b noop=%0b",
                 b_out_pc, b_out_op, b_out_fmt, b_out_imm, b_out_illegal, b_out_noop);
      end
    end
  end

  // Offer one instruction to instance a (sel=0) or b (sel=1); push the
  // expected entry when the accept is seen. lat: check presentation one
  // cycle after the accept (absence for a dropped NOP on b).
  task automatic send(input bit sel, input int v, input logic [63:0] pc, input bit lat);
    bit acc;
    bit dropped;
    logic rdy;
    dropped = sel && tbl[v].noop;
    if (sel) begin
      b_in_instr = tbl[v].instr; b_in_pc = pc; b_in_valid = 1'b1;
    end else begin
      a_in_instr = tbl[v].instr; a_in_pc = pc[31:0]; a_in_valid = 1'b1;
    end
    acc = 1'b0;
    for (int c = 0; c < 40 && !acc; c++) begin
      @(negedge clk);
      rdy = sel ? b_in_ready : a_in_ready;
      if (rdy) begin
        acc = 1'b1;
        if (!dropped) begin
          if (sel) qb.push_back(mk_exp(v, pc, 1'b1));
          else     qa.push_back(mk_exp(v, pc, 1'b0));
        end
      end
      @(posedge clk); #1;
    end
    if (sel) b_in_valid = 1'b0; else a_in_valid = 1'b0;
    chk(sel ? "b_accept" : "a_accept", 64'(acc), 64'd1);
    if (lat) begin
      @(negedge clk);
      chk(sel ? "b_latency" : "a_latency", 64'(sel ? b_out_valid : a_out_valid),
          dropped ? 64'd0 : 64'd1);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 20 && (qa.size() != 0 || qb.size() != 0); c++) @(posedge clk);
    #1;
    chk("a_drained", 64'(qa.size()), 64'd0);
    chk("b_drained", 64'(qb.size()), 64'd0);
  endtask

  int stream_v [5] = '{0, 1, 2, 6, 7};

  initial begin
    tbl[0]  = '{32'hFFF10093, 7'h13, 5'd1,  5'd2, 5'd31, 3'd0, 7'h7F, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    tbl[1]  = '{32'h00512423, 7'h23, 5'd8,  5'd2, 5'd5,  3'd2, 7'h00, 3'd2, 64'h0000_0000_0000_0008, 1'b0, 1'b0};
    tbl[2]  = '{32'hFE000EE3, 7'h63, 5'd29, 5'd0, 5'd0,  3'd0, 7'h7F, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0};
    tbl[3]  = '{32'h800000B7, 7'h37, 5'd1,  5'd0, 5'd0,  3'd0, 7'h40, 3'd4, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0};
    tbl[4]  = '{32'h00000000, 7'h00, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 3'd7, 64'h0,                   1'b1, 1'b0};
    tbl[5]  = '{32'h00000013, 7'h13, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 3'd1, 64'h0,                   1'b0, 1'b1};
    tbl[6]  = '{32'h008000EF, 7'h6F, 5'd1,  5'd0, 5'd8,  3'd0, 7'h00, 3'd5, 64'h0000_0000_0000_0008, 1'b0, 1'b0};
    tbl[7]  = '{32'h40208033, 7'h33, 5'd0,  5'd1, 5'd2,  3'd0, 7'h20, 3'd0, 64'h0,                   1'b0, 1'b0};
    tbl[8]  = '{32'h00000093, 7'h13, 5'd1,  5'd0, 5'd0,  3'd0, 7'h00, 3'd1, 64'h0,                   1'b0, 1'b0};
    tbl[9]  = '{32'h00000012, 7'h12, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 3'd7, 64'h0,                   1'b1, 1'b0};
    tbl[10] = '{32'h80000013, 7'h13, 5'd0,  5'd0, 5'd0,  3'd0, 7'h40, 3'd1, 64'hFFFF_FFFF_FFFF_F800, 1'b0, 1'b0};

    rst = 1'b1; a_flush = 1'b0; b_flush = 1'b0;
    a_in_valid = 1'b0; a_in_instr = '0; a_in_pc = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_instr = '0; b_in_pc = '0; b_out_ready = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_a_out_fmt", 64'(a_out_fmt), 64'd0);
    chk("rst_a_out_imm", 64'(a_out_imm), 64'd0);
    chk("rst_a_out_pc", 64'(a_out_pc), 64'd0);
    chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed decode on the 32-bit instance, one at a time.
    send(1'b0, 0,  64'h1000, 1'b1);
    send(1'b0, 1,  64'h1004, 1'b1);
    send(1'b0, 2,  64'h1008, 1'b1);
    send(1'b0, 6,  64'h100C, 1'b1);
    send(1'b0, 7,  64'h1010, 1'b1);
    send(1'b0, 8,  64'h1014, 1'b1);
    send(1'b0, 9,  64'h1018, 1'b1);
    send(1'b0, 10, 64'h101C, 1'b1);
    send(1'b0, 4,  64'h1020, 1'b1);
    send(1'b0, 5,  64'h1024, 1'b1);

    // 64-bit instance with NOP dropping.
    send(1'b1, 3, 64'hFFFF_FFFF_0000_1000, 1'b1);
    send(1'b1, 4, 64'hFFFF_FFFF_0000_1004, 1'b1);
    send(1'b1, 5, 64'hFFFF_FFFF_0000_1008, 1'b1);
    send(1'b1, 0, 64'hFFFF_FFFF_0000_100C, 1'b1);
    send(1'b1, 2, 64'hFFFF_FFFF_0000_1010, 1'b1);
    wait_drain();

    // Stream of 5 with out_ready low for the first 3 cycles.
    begin
      int idx;
      int acc_stall;
      idx = 0; acc_stall = 0;
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_instr = tbl[stream_v[0]].instr; a_in_pc = 32'h2000;
      for (int c = 0; c < 60 && idx < 5; c++) begin
        @(negedge clk);
        if (c == 2) chk("a_stall_in_ready", 64'(a_in_ready), 64'd0);
        if (a_in_ready) begin
          qa.push_back(mk_exp(stream_v[idx], 64'(32'h2000 + 32'(idx * 4)), 1'b0));
          idx++;
          if (c < 3) acc_stall++;
        end
        @(posedge clk); #1;
        if (c == 2) begin
          chk("a_stall_accepts", 64'(acc_stall), 64'(STALL_ACC));
          a_out_ready = 1'b1;
        end
        if (idx < 5) begin
          a_in_instr = tbl[stream_v[idx]].instr;
          a_in_pc    = 32'h2000 + 32'(idx * 4);
        end else begin
          a_in_valid = 1'b0;
        end
      end
      a_in_valid = 1'b0;
      chk("a_stream_accepted", 64'(idx), 64'd5);
    end
    wait_drain();

    // Flush with the stage full and in_valid held.
    a_out_ready = 1'b0;
    for (int k = 0; k < STALL_ACC; k++) send(1'b0, k, 64'(32'h3000 + k * 4), 1'b0);
    a_in_valid = 1'b1; a_in_instr = tbl[1].instr; a_in_pc = 32'h3100;
    @(negedge clk);
    chk("a_full_in_ready", 64'(a_in_ready), 64'd0);
    chk("a_full_out_valid", 64'(a_out_valid), 64'd1);
    @(posedge clk); #1;
    a_flush = 1'b1;
    @(negedge clk);
    chk("a_flush_in_ready", 64'(a_in_ready), 64'd0);
    @(posedge clk); #1;
    a_flush = 1'b0; a_in_valid = 1'b0;
    qa.delete();
    @(negedge clk);
    chk("a_post_flush_out_valid", 64'(a_out_valid), 64'd0);
    chk("a_post_flush_in_ready", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;

    // Flush on an empty stage with in_valid: nothing may be accepted.
    a_in_valid = 1'b1; a_in_instr = tbl[2].instr; a_in_pc = 32'h3200;
    a_flush = 1'b1;
    @(negedge clk);
    chk("a_flush_empty_in_ready", 64'(a_in_ready), 64'd0);
    @(posedge clk); #1;
    a_flush = 1'b0; a_in_valid = 1'b0;
    @(negedge clk);
    chk("a_flush_empty_out_valid", 64'(a_out_valid), 64'd0);
    @(posedge clk); #1;

    // Reset mid-stream.
    send(1'b0, 3, 64'h4000, 1'b0);
    rst = 1'b1;
    #1;
    chk("a_async_rst_out_valid", 64'(a_out_valid), 64'd0);
    qa.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("a_rst_release_in_ready", 64'(a_in_ready), 64'd1);
    chk("a_rst_release_out_valid", 64'(a_out_valid), 64'd0);
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    send(1'b0, 6, 64'h5000, 1'b1);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
